// File: rtl/eth_frame_tx_if.sv
// Payload-FIFO read side and TX-FIFO write side of the Ethernet framer, bundled as one port.
interface eth_frame_tx_if;
    logic       pl_rd_en_out;
    logic [7:0] pl_d_in;
    logic       pl_empty_in;
    logic       wr_en_out;
    logic [8:0] wr_d_out;
    logic       wr_chk_out;
    logic       wr_clr_out;
    logic       wr_full_in;

    modport master (
        output pl_rd_en_out, wr_en_out, wr_d_out, wr_chk_out, wr_clr_out,
        input  pl_d_in, pl_empty_in, wr_full_in
    );

    modport slave (
        input  pl_rd_en_out, wr_en_out, wr_d_out, wr_chk_out, wr_clr_out,
        output pl_d_in, pl_empty_in, wr_full_in
    );
endinterface

// File: rtl/eth_frame_tx.sv
// Ethernet II framer: header, FWFT payload, zero pad to minimum, then commit or discard. First write
// one cycle after the accepted start; wr_full_in or an empty payload FIFO stalls writes in place.
module eth_frame_tx #(
    parameter int unsigned MIN_PAYLOAD   = 46,
    parameter int unsigned MAX_PAYLOAD   = 1500,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic [47:0] mac_dst_in,
    input  logic [47:0] mac_src_in,
    input  logic [15:0] type_in,
    input  logic [10:0] len_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    eth_frame_tx_if.master bus
);

    localparam int unsigned SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [10:0]   MIN_LEN   = 11'(MIN_PAYLOAD);
    localparam logic [10:0]   MAX_LEN   = 11'(MAX_PAYLOAD);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TIMEOUT);

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
        logic [10:0] len;
    } hdr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_PAD,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    hdr_t          hdr_q, hdr_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          wr_en_q, wr_en_d;
    logic [8:0]    wr_d_q, wr_d_d;
    logic          chk_q, chk_d;
    logic          clr_q, clr_d;

    logic [111:0]  hdr_bits;
    logic [111:0]  hdr_shift;
    logic [10:0]   cnt_inc;
    logic [SW-1:0] stall_inc;
    logic          len_ge_min;
    logic          pl_rd_en;

    // Header byte cnt_q is brought to the top of the shifted vector (dst MSB goes first).
    assign hdr_bits   = {hdr_q.dst, hdr_q.src, hdr_q.etype};
    assign hdr_shift  = hdr_bits << {cnt_q[3:0], 3'b000};
    assign cnt_inc    = cnt_q + 11'd1;
    assign stall_inc  = stall_q + 1'b1;
    assign len_ge_min = (hdr_q.len >= MIN_LEN);
    assign pl_rd_en   = (state_q == S_PAYLOAD) && !bus.pl_empty_in && !bus.wr_full_in
                        && (cnt_q < hdr_q.len);

    assign bus.pl_rd_en_out = pl_rd_en;
    assign bus.wr_en_out    = wr_en_q;
    assign bus.wr_d_out     = wr_d_q;
    assign bus.wr_chk_out   = chk_q;
    assign bus.wr_clr_out   = clr_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign err_out          = err_q;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en_d = 1'b0;
        wr_d_d  = wr_d_q;
        chk_d   = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (len_in <= MAX_LEN) begin
                        hdr_d   = '{dst: mac_dst_in, src: mac_src_in, etype: type_in, len: len_in};
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        stall_d = '0;
                        state_d = S_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (!bus.wr_full_in) begin
                    wr_en_d = 1'b1;
                    wr_d_d  = {1'b0, hdr_shift[111:104]};
                    if (cnt_q == 11'd13) begin
                        cnt_d   = '0;
                        state_d = (hdr_q.len == 11'd0) ? S_PAD : S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pl_rd_en) begin
                    wr_en_d = 1'b1;
                    wr_d_d  = {(cnt_inc == hdr_q.len) && len_ge_min, bus.pl_d_in};
                    cnt_d   = cnt_inc;
                    stall_d = '0;
                    if (cnt_inc == hdr_q.len) begin
                        state_d = len_ge_min ? S_COMMIT : S_PAD;
                    end
                end else if (bus.pl_empty_in && !bus.wr_full_in) begin
                    // Only starvation counts toward the abort; TX backpressure freezes the count.
                    stall_d = stall_inc;
                    if (stall_inc == STALL_MAX) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_PAD: begin
                if (!bus.wr_full_in) begin
                    wr_en_d = 1'b1;
                    wr_d_d  = {cnt_inc == MIN_LEN, 8'h00};
                    cnt_d   = cnt_inc;
                    if (cnt_inc == MIN_LEN) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                chk_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                clr_d   = 1'b1;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            wr_d_q  <= '0;
            chk_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            wr_d_q  <= wr_d_d;
            chk_q   <= chk_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: FWFT payload source model, TX write monitor, inline assertions.
module tb_eth_frame_tx;

    localparam logic [47:0] DST   = 48'h0011_2233_4455;
    localparam logic [47:0] SRC   = 48'hAABB_CCDD_EEFF;
    localparam logic [15:0] ETYPE = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [47:0] dst_in = '0;
    logic [47:0] src_in = '0;
    logic [15:0] type_in = '0;
    logic [10:0] len_in = '0;
    logic        busy, done, err;

    eth_frame_tx_if bus();

    eth_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .mac_dst_in (dst_in),
        .mac_src_in (src_in),
        .type_in    (type_in),
        .len_in     (len_in),
        .busy_out   (busy),
        .done_out   (done),
        .err_out    (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Payload FIFO model: byte k of the current test is pl_pat + k, pl_avail bytes available.
    int         pops = 0, pl_base = 0, pl_avail = 0;
    logic [7:0] pl_pat = 8'h00;
    assign bus.pl_empty_in = (pops - pl_base) >= pl_avail;
    assign bus.pl_d_in     = pl_pat + 8'(pops - pl_base);
    always @(posedge clk) if (bus.pl_rd_en_out) pops <= pops + 1;

    // TX FIFO monitor, sampled on the falling edge.
    logic [8:0] cap [0:4095];
    int         cap_cyc [0:4095];
    int         cap_n = 0, cyc = 0;
    int         chk_n = 0, clr_n = 0, done_n = 0, err_n = 0;
    int         chk_cyc = 0, done_cyc = 0, full_viol = 0;
    logic       full_prev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en_out) begin
            cap[cap_n]     <= bus.wr_d_out;
            cap_cyc[cap_n] <= cyc;
            cap_n          <= cap_n + 1;
            if (full_prev) full_viol <= full_viol + 1;
        end
        full_prev <= bus.wr_full_in;
        if (bus.wr_chk_out) begin chk_n <= chk_n + 1; chk_cyc <= cyc; end
        if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
        if (bus.wr_clr_out) clr_n <= clr_n + 1;
        if (err) err_n <= err_n + 1;
    end

    logic [7:0] hdr_exp [14] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h08, 8'h00};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic setup_pl(input logic [7:0] pat, input int avail);
        pl_pat   = pat;
        pl_base  = pops;
        pl_avail = avail;
    endtask

    // Returns at 2 time units after the edge that samples start_in; t0 is the monitor cycle count there.
    task automatic start_frame(input logic [10:0] len, output int t0);
        @(posedge clk); #2;
        dst_in = DST; src_in = SRC; type_in = ETYPE; len_in = len;
        start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_end(input string tag, input int budget, input bit toggle);
        int  ev0;
        bit  seen;
        ev0  = done_n + clr_n + err_n;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk); #2;
            if (toggle) bus.wr_full_in = ((k % 5) < 3);
            if (done_n + clr_n + err_n != ev0) seen = 1'b1;
        end
        bus.wr_full_in = 1'b0;
        check({tag, "_timeout"}, seen, 1'b1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic verify_frame(input string tag, input int cap0, input int len, input logic [7:0] pat,
                                input int chk0, input int done0, input int t0);
        int         n, bad;
        logic [7:0] b;
        n   = 14 + ((len < 46) ? 46 : len);
        bad = 0;
        check({tag, "_count"}, cap_n - cap0, n);
        for (int i = 0; i < n; i++) begin
            if (i < 14)            b = hdr_exp[i];
            else if (i - 14 < len) b = pat + 8'(i - 14);
            else                   b = 8'h00;
            if (cap[cap0 + i] !== {(i == n - 1), b}) bad++;
        end
        check({tag, "_bytes"}, bad, 0);
        check({tag, "_latency"}, cap_cyc[cap0] - t0, 1);
        check({tag, "_chk_n"}, chk_n - chk0, 1);
        check({tag, "_done_n"}, done_n - done0, 1);
        check({tag, "_chk_cyc"}, chk_cyc - cap_cyc[cap0 + n - 1], 1);
        check({tag, "_done_cyc"}, done_cyc - chk_cyc, 0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int  t0, cap0, chk0, done0, clr0, err0, fv0;
        bit  hit;
        bus.wr_full_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", {busy, done, err, bus.wr_en_out, bus.wr_d_out, bus.wr_chk_out,
                             bus.wr_clr_out, bus.pl_rd_en_out}, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // len=64, payload 0x00..0x3F, no backpressure
        setup_pl(8'h00, 64);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n;
        start_frame(11'd64, t0);
        check("l64_busy", busy, 1'b1);
        wait_end("l64", 300, 1'b0);
        verify_frame("l64", cap0, 64, 8'h00, chk0, done0, t0);
        check("l64_pops", pops - pl_base, 64);

        // len=10 padded to 46
        setup_pl(8'hA0, 10);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n;
        start_frame(11'd10, t0);
        wait_end("l10", 300, 1'b0);
        verify_frame("l10", cap0, 10, 8'hA0, chk0, done0, t0);

        // len=0: pure padding, payload FIFO never popped even though it holds data
        setup_pl(8'h55, 8);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n;
        start_frame(11'd0, t0);
        wait_end("l0", 300, 1'b0);
        verify_frame("l0", cap0, 0, 8'h00, chk0, done0, t0);
        check("l0_no_pop", pops - pl_base, 0);

        // len=100 with wr_full_in 3 on / 2 off
        setup_pl(8'h10, 100);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n; fv0 = full_viol;
        start_frame(11'd100, t0);
        wait_end("l100", 600, 1'b1);
        verify_frame("l100", cap0, 100, 8'h10, chk0, done0, t0);
        check("l100_write_while_full", full_viol - fv0, 0);

        // len=200 with only 50 payload bytes: stall timeout abort
        setup_pl(8'h40, 50);
        cap0 = cap_n; chk0 = chk_n; clr0 = clr_n; err0 = err_n;
        start_frame(11'd200, t0);
        wait_end("abort", 3000, 1'b0);
        check("abort_clr", clr_n - clr0, 1);
        check("abort_err", err_n - err0, 1);
        check("abort_no_chk", chk_n - chk0, 0);
        check("abort_writes", cap_n - cap0, 64);
        check("abort_busy", busy, 1'b0);
        check("abort_pops", pops - pl_base, 50);

        // Next start after the abort behaves normally
        setup_pl(8'h80, 46);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n;
        start_frame(11'd46, t0);
        wait_end("l46", 300, 1'b0);
        verify_frame("l46", cap0, 46, 8'h80, chk0, done0, t0);

        // len=1501 rejected
        cap0 = cap_n; err0 = err_n;
        start_frame(11'd1501, t0);
        check("rej_err_pulse", err, 1'b1);
        check("rej_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("rej_err_n", err_n - err0, 1);
        check("rej_writes", cap_n - cap0, 0);
        check("rej_busy_after", busy, 1'b0);

        // Asynchronous reset in the middle of the header
        setup_pl(8'h00, 0);
        cap0 = cap_n;
        start_frame(11'd20, t0);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk); #1;
            if (cap_n - cap0 >= 7) hit = 1'b1;
        end
        check("rst_reach_byte7", hit, 1'b1);
        check("rst_byte7_val", cap[cap0 + 6], {1'b0, 8'hAA});
        rst = 1'b1;
        #1;
        check("rst_async_outs", {busy, done, err, bus.wr_en_out, bus.wr_d_out, bus.wr_chk_out,
                                 bus.wr_clr_out, bus.pl_rd_en_out}, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_idle_busy", busy, 1'b0);

        // After reset the framer is back in IDLE and accepts a frame
        setup_pl(8'h00, 0);
        cap0 = cap_n; chk0 = chk_n; done0 = done_n;
        start_frame(11'd0, t0);
        wait_end("post_rst", 300, 1'b0);
        verify_frame("post_rst", cap0, 0, 8'h00, chk0, done0, t0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
Ethernet transmit framer. It builds one Ethernet II frame per start request and writes it, a byte per cycle, into the ethernet TX frame FIFO.
- Frame content: 14-byte header from latched fields, then payload bytes pulled from a first-word-fall-through (FWFT) payload FIFO, then zero padding to the minimum frame size.
- Commit/discard: each frame is committed with a wr_chk pulse, or discarded with a wr_clr pulse if the payload FIFO underflows. The MAC appends the FCS.

Parameters:
MIN_PAYLOAD, 46, payload bytes below which zero padding is added
MAX_PAYLOAD, 1500, largest accepted payload_len
STALL_TIMEOUT, 1024, consecutive payload-empty cycles before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start_in  in  1  frame request, sampled in IDLE only
mac_dst_in  in  48  destination MAC, latched on accepted start
mac_src_in  in  48  source MAC, latched on accepted start
type_in  in  16  ethertype, latched on accepted start
len_in  in  11  payload byte count, latched on accepted start
busy_out  out  1  high from accepted start until return to IDLE
done_out  out  1  one-cycle pulse on frame commit
err_out  out  1  one-cycle pulse on rejected start or abort
pl_rd_en_out  out  1  payload FIFO pop (combinational)
pl_d_in  in  8  payload FIFO head byte (FWFT)
pl_empty_in  in  1  payload FIFO empty
wr_en_out  out  1  TX FIFO write strobe
wr_d_out  out  9  [7:0] byte, [8] last-byte-of-frame flag
wr_chk_out  out  1  TX FIFO commit pulse
wr_clr_out  out  1  TX FIFO discard-partial-frame pulse
wr_full_in  in  1  TX FIFO programmable-full, at least 2 entries of margin

Behaviour:
- Reset (async, rst high):
  - state=IDLE.
  - All registered outputs 0: busy_out, done_out, err_out, wr_en_out, wr_d_out, wr_chk_out, wr_clr_out.
  - Counters cleared.
  - A partial frame is abandoned without wr_clr. The TX FIFO shares rst and clears itself.
- Outputs: all registered except pl_rd_en_out.
  - pl_rd_en_out = (state==PAYLOAD) && !pl_empty_in && !wr_full_in && (byte count < latched len).
- IDLE:
  - On start_in with len_in<=MAX_PAYLOAD: latch all fields, busy_out<=1, byte counter<=0, go to HDR.
  - On start_in with len_in>MAX_PAYLOAD: err_out pulses 1 cycle, stay in IDLE, no writes.
  - start_in in any other state is ignored.
- HDR:
  - Each cycle with !wr_full_in: wr_en_out<=1 and wr_d_out<={1'b0, header byte}. Otherwise wr_en_out<=0.
  - Header byte order: dst[47:40] … dst[7:0], src[47:40] … src[7:0], type[15:8], type[7:0].
  - After byte 14: go to PAYLOAD if len>0, else PAD.
- PAYLOAD:
  - In a cycle where pl_rd_en_out=1: wr_en_out<=1, wr_d_out<={last, pl_d_in}.
  - last=1 only when this is payload byte len and len>=MIN_PAYLOAD.
  - After byte len: go to COMMIT if len>=MIN_PAYLOAD, else PAD.
- PAD:
  - Each cycle with !wr_full_in: write {last, 8'h00}.
  - last=1 on the byte that makes payload+pad = MIN_PAYLOAD. After it, go to COMMIT.
- Stall counter (PAYLOAD only):
  - Increments on cycles where pl_empty_in=1 and !wr_full_in.
  - Resets to 0 on any pop.
  - Cycles stalled by wr_full_in neither count nor reset it.
  - When it reaches STALL_TIMEOUT: go to ABORT.
- COMMIT: wr_en_out<=0, wr_chk_out<=1, done_out<=1 (one cycle), then IDLE with busy_out<=0.
  - wr_chk_out is asserted the cycle after the last-flagged write.
- ABORT: wr_en_out<=0, wr_clr_out<=1, err_out<=1 (one cycle), then IDLE with busy_out<=0.
- Latency: start_in sampled at edge N → first wr_en_out high after edge N+1.
  - Unstalled frame of P=max(len,46) payload bytes: 14+P write cycles, then 1 commit cycle.
- Width: byte counter is 11 bits; len compare is unsigned.
- Frame sizes: len=0 gives 60 written bytes; len=1500 gives 1514 written bytes.

Test Plan:
- len=64, payload FIFO preloaded 0x00..0x3F, TX never full → 78 writes: 14 header bytes in order, then 64 payload bytes. Only byte 78 has bit8=1. wr_chk_out and done_out pulse once, the cycle after byte 78.
- len=10, payload 0xA0..0xA9 → 14 header bytes + 10 payload bytes + 36 bytes of 0x00 = 60 writes. bit8=1 only on write 60. Commit follows.
- len=0 → 14 header bytes + 46 zeros. pl_rd_en_out never asserted. Commit follows.
- len=100, toggle wr_full_in 3 on / 2 off → no write while full. Byte order and count (114) are intact, with exactly one bit8 and one commit.
- len=200, payload FIFO supplies only 50 bytes → after STALL_TIMEOUT=1024 empty cycles, wr_clr_out and err_out pulse once. No wr_chk_out, busy_out drops, next start is accepted normally.
- len=1501 → err_out pulse, zero writes, busy_out stays 0. Separately, assert rst at header byte 7 → all outputs 0 immediately (asynchronously), state=IDLE.
